// File: rtl/a500_ram_pkg.sv
// rtl/a500_ram_pkg.sv - shared types and defaults for the A500 SRAM arbiter
package a500_ram_pkg;

    localparam int WAIT_STATES_DEF  = 1;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_CPU_ACK,
        ST_DMA_ACC,
        ST_DMA_ACK
    } arb_state_e;

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - two-stage synchronizer for asynchronous bus strobes
module bus_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one SRAM between the 68000 bus and the IDE DMA engine
module ram_arbiter import a500_ram_pkg::*; #(
    parameter int WAIT_STATES  = WAIT_STATES_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cpu_sel,
    input  logic       AS,
    input  logic       UDS,
    input  logic       LDS,
    input  logic       RW,
    input  logic       dma_req,
    input  logic       dma_rw,
    input  logic [1:0] dma_be,
    output logic       dma_ack,
    output logic       ram_ce,
    output logic       ram_oe,
    output logic [1:0] ram_we,
    output logic       addr_sel,
    output logic       dtack
);

    localparam logic [CNT_W-1:0] LAST_CYC   = CNT_W'(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rd_q, rd_d;
    logic [1:0]       mask_q, mask_d;
    logic             rdy_q;
    logic             as_sync;
    logic             cpu_req;
    logic             grant_cpu, grant_dma;

    logic             ram_ce_q, ram_ce_d;
    logic             ram_oe_q, ram_oe_d;
    logic [1:0]       ram_we_q, ram_we_d;
    logic             addr_sel_q, addr_sel_d;
    logic             dtack_q, dtack_d;
    logic             dma_ack_q, dma_ack_d;

    bus_sync #(.WIDTH(1)) u_as_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (AS),
        .q_o   (as_sync)
    );

    assign cpu_req = as_sync & cpu_sel;

    // rdy_q holds off grants for one edge after reset so DMA cannot win on the first edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            starve_q   <= '0;
            rd_q       <= 1'b1;
            mask_q     <= 2'b00;
            rdy_q      <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 2'b00;
            addr_sel_q <= 1'b0;
            dtack_q    <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            starve_q   <= starve_d;
            rd_q       <= rd_d;
            mask_q     <= mask_d;
            rdy_q      <= 1'b1;
            ram_ce_q   <= ram_ce_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            addr_sel_q <= addr_sel_d;
            dtack_q    <= dtack_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        starve_d   = starve_q;
        rd_d       = rd_q;
        mask_d     = mask_q;
        addr_sel_d = addr_sel_q;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (rdy_q) begin
                    grant_dma = dma_req && (!cpu_req || starve_q == STARVE_MAX);
                    grant_cpu = cpu_req && !grant_dma;
                end
                if (grant_cpu) begin
                    state_d    = ST_CPU_ACC;
                    rd_d       = RW;
                    mask_d     = {UDS, LDS};
                    addr_sel_d = 1'b0;
                    if (!dma_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (grant_dma) begin
                    state_d    = ST_DMA_ACC;
                    rd_d       = dma_rw;
                    mask_d     = dma_be;
                    addr_sel_d = 1'b1;
                    starve_d   = '0;
                end else if (!dma_req) begin
                    starve_d = '0;
                end
            end
            ST_CPU_ACC: begin
                if (!as_sync) begin
                    state_d = ST_IDLE;
                end else if (cyc_q == LAST_CYC) begin
                    state_d = ST_CPU_ACK;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_CPU_ACK: begin
                if (!as_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DMA_ACC: begin
                if (cyc_q == LAST_CYC) begin
                    state_d = ST_DMA_ACK;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DMA_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q
    always_comb begin
        ram_ce_d  = (state_d == ST_CPU_ACC) || (state_d == ST_DMA_ACC);
        ram_oe_d  = ram_ce_d && rd_d;
        ram_we_d  = (ram_ce_d && !rd_d && cyc_d != '0) ? mask_d : 2'b00;
        dtack_d   = (state_d == ST_CPU_ACK);
        dma_ack_d = (state_d == ST_DMA_ACK);
    end

    assign ram_ce   = ram_ce_q;
    assign ram_oe   = ram_oe_q;
    assign ram_we   = ram_we_q;
    assign addr_sel = addr_sel_q;
    assign dtack    = dtack_q;
    assign dma_ack  = dma_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

    localparam int WS   = 1;
    localparam int SL   = 4;
    localparam int LAST = WS + 1;

    logic       CLK     = 1'b0;
    logic       RST     = 1'b0;
    logic       cpu_sel = 1'b0;
    logic       AS      = 1'b0;
    logic       UDS     = 1'b0;
    logic       LDS     = 1'b0;
    logic       RW      = 1'b1;
    logic       dma_req = 1'b0;
    logic       dma_rw  = 1'b1;
    logic [1:0] dma_be  = 2'b00;
    logic       dma_ack, ram_ce, ram_oe, addr_sel, dtack;
    logic [1:0] ram_we;
    logic [6:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    // {ce, oe, we[1:0], addr_sel, dtack, dma_ack}
    assign obs = {ram_ce, ram_oe, ram_we, addr_sel, dtack, dma_ack};

    always #5 CLK = ~CLK;

    ram_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cpu_sel  (cpu_sel),
        .AS       (AS),
        .UDS      (UDS),
        .LDS      (LDS),
        .RW       (RW),
        .dma_req  (dma_req),
        .dma_rw   (dma_rw),
        .dma_be   (dma_be),
        .dma_ack  (dma_ack),
        .ram_ce   (ram_ce),
        .ram_oe   (ram_oe),
        .ram_we   (ram_we),
        .addr_sel (addr_sel),
        .dtack    (dtack)
    );

    task automatic idle(input int n);
        AS      = 1'b0;
        dma_req = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (ram_ce !== 1'b1 && lat < 30);
    endtask

    task automatic cpu_access(input logic rd, input logic uds, input logic lds,
                              input int hold, input int exp_lat, input string tag);
        int         lat;
        int         n;
        logic [6:0] exp_v;
        cpu_sel = 1'b1;
        RW      = rd;
        UDS     = uds;
        LDS     = lds;
        AS      = 1'b1;
        wait_grant(lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s grant_latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
        end
        for (int k = 0; k <= LAST; k++) begin
            if (k > 0) @(negedge CLK);
            exp_v = {1'b1, rd, (k == 0 || rd) ? 2'b00 : {uds, lds}, 3'b000};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s access_cyc%0d: got %b, expected %b", tag, k, obs, exp_v);
            end
            if (k == 0) begin
                RW  = 1'($urandom);
                UDS = 1'($urandom);
                LDS = 1'($urandom);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge CLK);
            n_cmp++;
            if (obs !== 7'b0000010) begin
                n_err++;
                $display("FAIL %s dtack_hold%0d: got %b, expected %b", tag, h, obs, 7'b0000010);
            end
        end
        AS = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (dtack !== 1'b0 && n < 10);
        n_cmp++;
        if (n !== 3) begin
            n_err++;
            $display("FAIL %s dtack_release: got %0d cycles, expected 3", tag, n);
        end
        n_cmp++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL %s idle_after: got %b, expected %b", tag, obs, 7'b0000000);
        end
    endtask

    task automatic dma_access(input logic rd, input logic [1:0] be,
                              input int exp_lat, input string tag);
        int         lat;
        logic [6:0] exp_v;
        dma_rw  = rd;
        dma_be  = be;
        dma_req = 1'b1;
        wait_grant(lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s grant_latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
        end
        for (int k = 0; k <= LAST; k++) begin
            if (k > 0) @(negedge CLK);
            exp_v = {1'b1, rd, (k == 0 || rd) ? 2'b00 : be, 3'b100};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s access_cyc%0d: got %b, expected %b", tag, k, obs, exp_v);
            end
            if (k == 0) begin
                dma_rw = 1'($urandom);
                dma_be = 2'($urandom);
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (obs !== 7'b0000101) begin
            n_err++;
            $display("FAIL %s ack_pulse: got %b, expected %b", tag, obs, 7'b0000101);
        end
        dma_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (obs !== 7'b0000100) begin
            n_err++;
            $display("FAIL %s after_ack: got %b, expected %b", tag, obs, 7'b0000100);
        end
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        dma_req = 1'b1;
        dma_rw  = 1'b0;
        dma_be  = 2'b11;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, expected %b", obs, 7'b0000000);
        end
        #2 RST = 1'b0;
        dma_access(1'b0, 2'b11, 2, "post_reset_dma");
        idle(2);
    endtask

    task automatic test_cpu_read();
        cpu_access(1'b1, 1'b0, 1'b0, 2, 3, "cpu_read");
        idle(1);
    endtask

    task automatic test_cpu_write();
        cpu_access(1'b0, 1'b1, 1'b0, 0, 3, "cpu_byte_write");
        cpu_access(1'b0, 1'b0, 1'b0, 1, 3, "cpu_null_write");
        cpu_access(1'b0, 1'b1, 1'b1, 0, 3, "cpu_word_write");
        idle(1);
    endtask

    task automatic test_dma();
        dma_access(1'b0, 2'b01, 1, "dma_write_lo");
        dma_access(1'b1, 2'b10, 1, "dma_read");
        idle(1);
    endtask

    task automatic test_abort();
        int         lat;
        logic [6:0] exp_v;
        cpu_sel = 1'b1;
        RW      = 1'b0;
        UDS     = 1'b1;
        LDS     = 1'b1;
        AS      = 1'b1;
        wait_grant(lat);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL abort grant_latency: got %0d cycles, expected 3", lat);
        end
        AS = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            exp_v = (k <= 2) ? 7'b1011000 : 7'b0000000;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL abort cyc%0d: got %b, expected %b", k, obs, exp_v);
            end
        end
        dma_access(1'b1, 2'b00, 1, "post_abort_dma");
        idle(1);
    endtask

    task automatic test_starvation();
        int   g       = 0;
        int   cyc     = 0;
        int   cnt     = 0;
        int   n       = 0;
        logic prev_ce = 1'b0;
        logic dropped = 1'b0;
        logic exp_dma;
        cpu_sel = 1'b1;
        RW      = 1'b1;
        dma_rw  = 1'b1;
        dma_be  = 2'b11;
        AS      = 1'b1;
        dma_req = 1'b1;
        while (g < 11 && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (ram_ce === 1'b1 && prev_ce === 1'b0) begin
                exp_dma = (g == 0) || (cnt == SL);
                n_cmp++;
                if (addr_sel !== exp_dma) begin
                    n_err++;
                    $display("FAIL starve_grant%0d: got addr_sel %b, expected %b", g, addr_sel, exp_dma);
                end
                if (exp_dma) cnt = 0;
                else cnt++;
                if (addr_sel === 1'b0) dropped = 1'b0;
                g++;
                if (g == 11) AS = 1'b0;
            end
            prev_ce = ram_ce;
            if (g < 11) begin
                if (dtack === 1'b1 && !dropped) begin
                    AS      = 1'b0;
                    dropped = 1'b1;
                end else if (!AS && dropped) begin
                    AS = 1'b1;
                end
            end
        end
        n_cmp++;
        if (g !== 11) begin
            n_err++;
            $display("FAIL starve_timeout: got %0d grants, expected 11", g);
        end
        AS = 1'b0;
        while (dma_ack !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        idle(4);
    endtask

    task automatic test_reset_mid_dma();
        int lat;
        dma_rw  = 1'b0;
        dma_be  = 2'b10;
        dma_req = 1'b1;
        wait_grant(lat);
        @(negedge CLK);
        n_cmp++;
        if (obs !== 7'b1010100) begin
            n_err++;
            $display("FAIL rst_dma strobe: got %b, expected %b", obs, 7'b1010100);
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL rst_dma async_clear: got %b, expected %b", obs, 7'b0000000);
        end
        @(negedge CLK);
        n_cmp++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL rst_dma held: got %b, expected %b", obs, 7'b0000000);
        end
        #2 RST = 1'b0;
        dma_access(1'b0, 2'b10, 2, "rst_dma_regrant");
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                cpu_access(1'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 3)), 3, "rand_cpu");
            end else begin
                dma_access(1'($urandom), 2'($urandom), 1, "rand_dma");
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_dma();
        test_abort();
        test_starvation();
        test_reset_mid_dma();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
